// File: rtl/spi_slave_burst_pkg.sv
// rtl/spi_slave_burst_pkg.sv - shared defaults, FSM encoding and helpers for the burst SPI slave
package spi_slave_burst_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 6;

    // Wire position of the R/W flag inside the header (0 = first bit clocked in).
    localparam int HDR_RW_POS = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_WRITE  = 2'd2,
        ST_READ   = 2'd3
    } spi_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - input synchroniser with registered rise/fall detection
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Reset to the pin's idle level so leaving reset does not fake an edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
            fall   <= ~sync_q[SYNC_STAGES-1] & prev_q;
        end
    end

    assign level = prev_q;

endmodule

// File: rtl/spi_slave_burst.sv
// rtl/spi_slave_burst.sv - oversampling SPI slave, header decode and auto-increment register burst
module spi_slave_burst
    import spi_slave_burst_pkg::*;
#(
    parameter int   DATA_W      = DEF_DATA_W,
    parameter int   ADDR_W      = DEF_ADDR_W,
    parameter logic CPOL        = 1'b0,
    parameter logic CPHA        = 1'b0,
    parameter int   SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] address,
    output logic              we,
    output logic              re,
    output logic              busy,
    output logic              frame_err
);

    localparam int   HDR_BITS   = 1 + ADDR_W;
    localparam int   CNT_W      = $clog2(max_int(DATA_W, HDR_BITS));
    // sclk level right after a sample edge: rising when CPOL==CPHA, else falling.
    localparam logic SAMPLE_LVL = (CPOL == CPHA);

    spi_state_e        state, state_next;
    logic [CNT_W-1:0]  bit_cnt, cnt_next;
    logic [HDR_BITS-2:0] hdr_sr;
    logic [HDR_BITS-1:0] hdr_full;
    logic [DATA_W-2:0] rx_sr;
    logic [DATA_W-1:0] rx_full;
    logic [DATA_W-1:0] tx_sr;
    logic [SYNC_STAGES:0] mosi_q;
    logic              mosi_s, hdr_rw;
    logic              sclk_lvl, sclk_rise, sclk_fall;
    logic              ss_lvl, ss_rise, ss_fall;
    logic              ss_active, sclk_edge, sample, shift;
    logic              hdr_done, word_done, err_set;
    logic              inc_pend, re_d;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sclk_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (sclk),
        .level (sclk_lvl),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (ss),
        .level (ss_lvl),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    // One extra flop keeps mosi aligned with the edge-detected sclk/ss.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mosi_q <= '0;
        end else begin
            mosi_q <= {mosi_q[SYNC_STAGES-1:0], mosi};
        end
    end

    assign mosi_s    = mosi_q[SYNC_STAGES];
    assign ss_active = ~ss_lvl | ss_rise;
    assign sclk_edge = (sclk_rise | sclk_fall) & ss_active;
    assign sample    = sclk_edge & (sclk_lvl == SAMPLE_LVL);
    assign shift     = sclk_edge & (sclk_lvl != SAMPLE_LVL);
    assign hdr_full  = {hdr_sr, mosi_s};
    assign rx_full   = {rx_sr, mosi_s};
    assign hdr_rw    = hdr_full[HDR_BITS-1-HDR_RW_POS];

    always_comb begin
        state_next = state;
        cnt_next   = bit_cnt;
        hdr_done   = 1'b0;
        word_done  = 1'b0;
        err_set    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_next = ST_HEADER;
                    cnt_next   = '0;
                end
            end
            ST_HEADER: begin
                if (sample) begin
                    if (bit_cnt == CNT_W'(HDR_BITS - 1)) begin
                        hdr_done   = 1'b1;
                        cnt_next   = '0;
                        state_next = hdr_rw ? ST_WRITE : ST_READ;
                    end else begin
                        cnt_next = bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                if (sample) begin
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        word_done = 1'b1;
                        cnt_next  = '0;
                    end else begin
                        cnt_next = bit_cnt + 1'b1;
                    end
                end
            end
        endcase
        // A coincident last sample is folded in above, so the word completes first.
        if (ss_rise && state != ST_IDLE) begin
            err_set    = (cnt_next != '0);
            state_next = ST_IDLE;
            cnt_next   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            hdr_sr    <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            address   <= '0;
            data_out  <= '0;
            we        <= 1'b0;
            re        <= 1'b0;
            re_d      <= 1'b0;
            inc_pend  <= 1'b0;
            busy      <= 1'b0;
            miso      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            bit_cnt   <= cnt_next;
            busy      <= (state_next != ST_IDLE);
            frame_err <= err_set;
            we        <= 1'b0;
            re        <= (hdr_done & ~hdr_rw) | (word_done & (state == ST_READ));
            re_d      <= re;
            if (sample && state == ST_HEADER) begin
                hdr_sr <= hdr_full[HDR_BITS-2:0];
            end
            if (sample && (state == ST_WRITE || state == ST_READ)) begin
                rx_sr <= rx_full[DATA_W-2:0];
            end
            if (inc_pend) begin
                address  <= address + 1'b1;
                inc_pend <= 1'b0;
            end
            if (hdr_done) begin
                address <= hdr_full[ADDR_W-1:0];
            end
            if (word_done && state == ST_WRITE) begin
                data_out <= rx_full;
                we       <= 1'b1;
                inc_pend <= 1'b1;
            end
            if (word_done && state == ST_READ) begin
                address <= address + 1'b1;
            end
            if (shift && state == ST_READ) begin
                miso  <= tx_sr[DATA_W-1];
                tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            end
            if (re_d) begin
                tx_sr <= data_in;
            end
            if (state_next != ST_READ) begin
                miso <= 1'b0;
            end
        end
    end

endmodule
